tristate_bus_reader: RTL
========================

Name: tristate_bus_reader

Overview:
- Read-side master for a bank of tri-state 32-bit registers sharing one bus in the multdiv datapath.
- Takes an index request, drives exactly one register read enable for a configurable settle time, then samples the shared bus.
- Returns the captured word over a valid/ready handshake.
- Guarantees at most one driver on the bus at any time.

Parameters:
- WIDTH, 32, bus and data width.
- NUM_REGS, 4, number of registers on the bus (1..16).
- IDX_W, 2, request index width; must satisfy 2^IDX_W >= NUM_REGS.
- SETTLE, 1, extra cycles the enable is held before sampling (0..15).

Ports:
- clk  input  1  clock, rising edge.
- clr  input  1  reset, asynchronous, active-high.
- req_valid  input  1  read request present.
- req_ready  output  1  block can accept a request.
- req_idx  input  IDX_W  register to read.
- r_en  output  NUM_REGS  one-hot read enables to the registers' tri-state outputs.
- bus_in  input  WIDTH  shared tri-state bus.
- rd_valid  output  1  rd_data holds a result.
- rd_ready  input  1  consumer accepts the result.
- rd_data  output  WIDTH  captured word.
- busy  output  1  high in any non-IDLE state.

Behaviour:
- Reset (async clr high): state IDLE; r_en=0, rd_valid=0, rd_data=0, busy=0, counter=0; req_ready=1 once clr deasserts. Reset mid-operation drops r_en immediately, without waiting for a clock edge, and discards the transaction.
- Outputs: all are registered except req_ready, which is exactly (state==IDLE).
- States: IDLE, DRIVE, RESP.
- IDLE:
  - Accept on req_valid && req_ready at the clock edge.
  - If req_idx < NUM_REGS: r_en <= one-hot(req_idx), counter <= SETTLE, go to DRIVE.
  - Otherwise (out of range): r_en stays 0, rd_data <= 0, rd_valid <= 1, go to RESP.
- DRIVE:
  - If counter != 0: counter decrements each edge and r_en is held.
  - When counter == 0 at an edge: rd_data <= bus_in, r_en <= 0, rd_valid <= 1, go to RESP.
  - r_en is therefore high for exactly SETTLE+1 cycles. Requests are ignored during DRIVE.
- RESP:
  - rd_valid and rd_data are held stable until rd_ready is high at an edge; then rd_valid <= 0 and the state returns to IDLE.
  - A new request is accepted no earlier than the cycle after the handshake, so throughput is one read per SETTLE+3 cycles.
- Latency: accept at edge E0 -> rd_valid high after edge E0+SETTLE+1.
- Bus safety:
  - r_en is never multi-hot.
  - r_en is all-zero in IDLE and RESP.
  - r_en is all-zero for at least one cycle between consecutive reads.
- Width rules:
  - bus_in is sampled full-width with no masking.
  - Out-of-range reads return all zeros.
- Simultaneous events: rd_ready low in RESP stalls indefinitely with no loss of data.

Optional Feature:
- Macro: TRISTATE_BUS_READER_ERR_EN.
- With the macro defined, an extra output rd_err (1 bit) is present:
  - rd_err is registered and valid with rd_valid.
  - It is 1 for an out-of-range request and 0 otherwise.
  - It resets to 0 and clears on the rd_valid/rd_ready handshake.
- Without the macro, the rd_err port does not exist. Out-of-range requests still complete silently with rd_data=0.

Decomposition:
- Shared package (multdiv_bus_pkg):
  - state enum (IDLE=2'd0, DRIVE=2'd1, RESP=2'd2);
  - default WIDTH constant 32;
  - settle counter width constant 4.
- One natural sub-module: settle_down_counter, a loadable 4-bit down counter with async clr and a zero flag, instantiated once.

Test Plan:
- SETTLE=1, register 2 drives 32'hDEADBEEF; request idx=2 with rd_ready=1:
  - r_en=4'b0100 for exactly 2 cycles;
  - rd_valid high 2 edges after accept with rd_data=32'hDEADBEEF;
  - req_ready returns to 1 the cycle after the handshake.
- SETTLE=0, back-to-back requests idx=0 then idx=3 with rd_ready held high:
  - r_en sequence 0001, 0000, 0000, 1000;
  - r_en is never multi-hot;
  - results 0 then 3 are delivered in order.
- rd_ready held low 10 cycles after a read of 32'h12345678:
  - rd_valid and rd_data are stable for all 10 cycles;
  - req_valid asserted meanwhile is not accepted (req_ready=0).
- NUM_REGS=3, request idx=3:
  - r_en stays 000; rd_data=0 with rd_valid.
  - With TRISTATE_BUS_READER_ERR_EN: rd_err=1. On a following valid read: rd_err=0.
- clr pulsed asynchronously mid-DRIVE (between clock edges) with r_en=0010:
  - r_en, rd_valid and busy go 0 before the next edge;
  - after release, req_ready=1 and a fresh read of idx=1 completes correctly.

Source files
------------

// File: rtl/multdiv_bus_pkg.sv
// -----------------------------------------------------------------------------
// multdiv_bus_pkg
// Shared definitions for the multdiv tri-state register bus read side.
//   busState_t      : read master state encoding (IDLE, DRIVE, RESP)
//   DEFAULT_WIDTH   : default bus / data width
//   SETTLE_CNT_W    : width of the settle-time down counter
// -----------------------------------------------------------------------------
package multdiv_bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      RESP  = 2'd2
   } busState_t;

   localparam int DEFAULT_WIDTH = 32;
   localparam int SETTLE_CNT_W  = 4;

endpackage

// File: rtl/settle_down_counter.sv
// -----------------------------------------------------------------------------
// settle_down_counter
// Loadable down counter that times how long a register read enable is held
// before the shared bus is sampled. Stops at zero and flags it.
// Ports:
//   clk          in   clock, rising edge
//   clr          in   asynchronous active-high reset (count -> 0)
//   i_load       in   load i_loadValue this edge (wins over i_dec)
//   i_loadValue  in   SETTLE_CNT_W-bit load value
//   i_dec        in   decrement this edge (saturates at zero)
//   o_zero       out  count is zero
// -----------------------------------------------------------------------------
module settle_down_counter
   import multdiv_bus_pkg::*;
(
   input  logic                    clk,
   input  logic                    clr,
   input  logic                    i_load,
   input  logic [SETTLE_CNT_W-1:0] i_loadValue,
   input  logic                    i_dec,
   output logic                    o_zero
);

   logic [SETTLE_CNT_W-1:0] r_count;

   // Count register: a load always takes priority so a new read can restart
   // the settle window; decrementing stops at zero so the flag stays stable
   // while the owning FSM decides what to do.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_loadValue;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - SETTLE_CNT_W'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/tristate_bus_reader.sv
// -----------------------------------------------------------------------------
// tristate_bus_reader
// Read master for a bank of tri-state registers sharing one bus. A request
// selects one register, its read enable is held for SETTLE+1 cycles, the bus
// is sampled and the word is returned over a valid/ready handshake. At most
// one enable is ever high, and enables are low outside the DRIVE state.
//
// Optional feature macro: TRISTATE_BUS_READER_ERR_EN
//   When defined, adds output rd_err, set for out-of-range requests.
//
// Ports:
//   clk        in   clock, rising edge
//   clr        in   asynchronous active-high reset
//   req_valid  in   read request present
//   req_ready  out  request accepted this edge when valid (state == IDLE)
//   req_idx    in   register index to read
//   r_en       out  one-hot register read enables
//   bus_in     in   shared tri-state bus
//   rd_valid   out  rd_data holds a result
//   rd_ready   in   consumer accepts the result
//   rd_data    out  captured word (zero for out-of-range requests)
//   busy       out  not in IDLE
//   rd_err     out  (macro only) result came from an out-of-range request
// -----------------------------------------------------------------------------
module tristate_bus_reader
   import multdiv_bus_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int NUM_REGS = 4,
   parameter int IDX_W    = 2,
   parameter int SETTLE   = 1
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [IDX_W-1:0]    req_idx,
   output logic [NUM_REGS-1:0] r_en,
   input  logic [WIDTH-1:0]    bus_in,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic [WIDTH-1:0]    rd_data,
   output logic                busy
`ifdef TRISTATE_BUS_READER_ERR_EN
   ,
   output logic                rd_err
`endif
);

   localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE);

   busState_t           r_state;
   logic [NUM_REGS-1:0] r_enables;
   logic                r_valid;
   logic [WIDTH-1:0]    r_data;
   logic                r_busy;

   busState_t           w_stateNext;
   logic [NUM_REGS-1:0] w_enNext;
   logic                w_validNext;
   logic [WIDTH-1:0]    w_dataNext;
   logic [NUM_REGS-1:0] w_onehot;
   logic [31:0]         w_idxWide;
   logic                w_inRange;
   logic                w_load;
   logic                w_dec;
   logic                w_zero;

   settle_down_counter u_settle (
      .clk         (clk),
      .clr         (clr),
      .i_load      (w_load),
      .i_loadValue (SETTLE_LOAD),
      .i_dec       (w_dec),
      .o_zero      (w_zero)
   );

   assign w_idxWide = 32'(req_idx);
   assign w_inRange = (w_idxWide < 32'(NUM_REGS));

   // Decode the requested index into a single enable bit. Indices past the
   // last register decode to all-zero, so no register is ever driven for them.
   always_comb begin
      w_onehot = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_idxWide == 32'(i)) begin
            w_onehot[i] = 1'b1;
         end
      end
   end

   // Next-state and next-output logic. Every registered output holds its
   // value by default; only the transitions below change them. The enable
   // is cleared on the same edge that samples the bus, which guarantees a
   // dead cycle on the bus before any following read can drive it.
   always_comb begin
      w_stateNext = r_state;
      w_enNext    = r_enables;
      w_validNext = r_valid;
      w_dataNext  = r_data;
      w_load      = 1'b0;
      w_dec       = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               if (w_inRange) begin
                  w_enNext    = w_onehot;
                  w_load      = 1'b1;
                  w_stateNext = DRIVE;
               end else begin
                  w_enNext    = '0;
                  w_dataNext  = '0;
                  w_validNext = 1'b1;
                  w_stateNext = RESP;
               end
            end
         end
         DRIVE: begin
            if (w_zero) begin
               w_dataNext  = bus_in;
               w_enNext    = '0;
               w_validNext = 1'b1;
               w_stateNext = RESP;
            end else begin
               w_dec = 1'b1;
            end
         end
         RESP: begin
            if (rd_ready) begin
               w_validNext = 1'b0;
               w_stateNext = IDLE;
            end
         end
         default: begin
            w_enNext    = '0;
            w_validNext = 1'b0;
            w_stateNext = IDLE;
         end
      endcase
   end

   // State and output registers. The asynchronous clear releases the bus at
   // once, even mid-read, and abandons any transaction in flight.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state   <= IDLE;
         r_enables <= '0;
         r_valid   <= 1'b0;
         r_data    <= '0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_enables <= w_enNext;
         r_valid   <= w_validNext;
         r_data    <= w_dataNext;
         r_busy    <= (w_stateNext != IDLE);
      end
   end

`ifdef TRISTATE_BUS_READER_ERR_EN
   logic r_err;

   // Error flag travels with rd_valid: set when an out-of-range request is
   // answered, cleared by a normal capture or by the result handshake.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_err <= 1'b0;
      end else begin
         case (r_state)
            IDLE:    if (req_valid && !w_inRange) r_err <= 1'b1;
            DRIVE:   if (w_zero) r_err <= 1'b0;
            RESP:    if (rd_ready) r_err <= 1'b0;
            default: r_err <= 1'b0;
         endcase
      end
   end

   assign rd_err = r_err;
`endif

   assign req_ready = (r_state == IDLE);
   assign r_en      = r_enables;
   assign rd_valid  = r_valid;
   assign rd_data   = r_data;
   assign busy      = r_busy;

endmodule
